// File: rtl/pong_packet_receiver.sv
// pong_packet_receiver: UART decoder for remote pong state packets; define PONG_RX_CHECKSUM_EN to require an XOR checksum byte
module pong_packet_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [8:0] paddle_y,
  output logic [3:0] score,
  output logic       packet_valid,
  output logic       frame_err,
  output logic       chk_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam logic [1:0] HUNT = 2'd0, PAYLOAD = 2'd1;
`ifdef PONG_RX_CHECKSUM_EN
  localparam logic [1:0] CHECK = 2'd2;
  localparam int WW = 32;
  logic [7:0] csum;
`else
  localparam int WW = 24;
  assign chk_err = 1'b0;
`endif
  logic rx_meta, rx_sync, rx_prev;
  logic [1:0] state, pstate, idx;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [WW-1:0] word;
  logic tick, byte_done, stop_bad;
  // Bit timing: START waits half a bit to land mid-bit, later samples are a full bit apart
  always_comb begin
    tick = cnt == ((state == START) ? HALF : FULL);
    byte_done = state == STOP && tick && rx_sync;
    stop_bad = state == STOP && tick && !rx_sync;
  end
  // Two-flop synchronizer plus one delay stage for start-edge detection; idle-high reset avoids a false edge
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  // Byte receiver: IDLE -> START -> DATA x8 -> STOP, straight back to IDLE after the stop sample
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (rx_prev && !rx_sync) state <= START;
        START: if (tick) state <= rx_sync ? IDLE : DATA;
        DATA: if (tick) begin
          shreg <= {rx_sync, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        default: if (tick) state <= IDLE;
      endcase
    end
  // Packet parser: acts on the stop-sample edge itself so results appear in the very next cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pstate <= HUNT;
      idx <= '0;
      word <= '0;
      ball_x <= '0;
      ball_y <= '0;
      paddle_y <= '0;
      score <= '0;
      packet_valid <= 1'b0;
      frame_err <= 1'b0;
`ifdef PONG_RX_CHECKSUM_EN
      csum <= '0;
      chk_err <= 1'b0;
`endif
    end else begin
      packet_valid <= 1'b0;
      frame_err <= stop_bad;
`ifdef PONG_RX_CHECKSUM_EN
      chk_err <= 1'b0;
`endif
      if (stop_bad) pstate <= HUNT;
      else if (byte_done)
        case (pstate)
          HUNT: if (shreg == SYNC_BYTE) begin
            pstate <= PAYLOAD;
            idx <= '0;
`ifdef PONG_RX_CHECKSUM_EN
            csum <= '0;
`endif
          end
          PAYLOAD: begin
            word <= WW'({word, shreg});
            idx <= idx + 1'b1;
`ifdef PONG_RX_CHECKSUM_EN
            csum <= csum ^ shreg;
            if (idx == 2'd3) pstate <= CHECK;
`else
            if (idx == 2'd3) begin
              pstate <= HUNT;
              {ball_x, ball_y, paddle_y, score} <= {word, shreg};
              packet_valid <= 1'b1;
            end
`endif
          end
`ifdef PONG_RX_CHECKSUM_EN
          CHECK: begin
            pstate <= HUNT;
            if (shreg == csum) begin
              {ball_x, ball_y, paddle_y, score} <= word;
              packet_valid <= 1'b1;
            end else chk_err <= 1'b1;
          end
`endif
          default: pstate <= HUNT;
        endcase
    end
endmodule
